// File: rtl/tristate_bus_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM encodings and counter widths.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int HOLD_W = 8;
    localparam int TURN_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int CHANNELS = 4,
    localparam int IDX_W = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [CHANNELS-1:0] pick,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);

    always_comb begin
        int cand;
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = (int'(ptr) + k) % CHANNELS;
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                idx        = cand[IDX_W-1:0];
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with bounded tenure and forced turnaround.
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WIDTH-1:0]    data_in,
    output logic [CHANNELS-1:0]          grant,
    output logic [$clog2(CHANNELS)-1:0]  owner,
    output logic                         bus_oe,
    output tri   [WIDTH-1:0]             bus
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = (TURNAROUND == 0) ? '0 : TURN_W'(TURNAROUND - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic [CHANNELS-1:0] grant_d;
    logic [IDX_W-1:0]    owner_d;
    logic                oe_d;

    logic [CHANNELS-1:0] pick;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                release_now;
    logic [IDX_W-1:0]    owner_next;

    rr_pick #(.CHANNELS(CHANNELS)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Request drop and hold expiry merge into one release condition.
    assign release_now = !req[owner] || ((MAX_HOLD != 0) && (hold_q == HOLD_LAST));
    assign owner_next  = (owner == IDX_W'(CHANNELS - 1)) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = DRIVE;
            DRIVE:   if (release_now) state_d = (TURNAROUND == 0) ? IDLE : TURN;
            TURN:    if (turn_q == TURN_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant;
        owner_d = owner;
        oe_d    = bus_oe;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        case (state_q)
            IDLE: begin
                grant_d = pick;
                owner_d = pick_idx;
                oe_d    = pick_valid;
                hold_d  = '0;
            end
            DRIVE: begin
                if (release_now) begin
                    grant_d = '0;
                    owner_d = '0;
                    oe_d    = 1'b0;
                    ptr_d   = owner_next;
                    turn_d  = '0;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            TURN: begin
                turn_d = turn_q + TURN_W'(1);
            end
            default: begin
                grant_d = '0;
                owner_d = '0;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            owner  <= '0;
            bus_oe <= 1'b0;
            ptr_q  <= '0;
            hold_q <= '0;
            turn_q <= '0;
        end else begin
            grant  <= grant_d;
            owner  <= owner_d;
            bus_oe <= oe_d;
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
            turn_q <= turn_d;
        end
    end

    // Data path is unregistered so the bus tracks the owner's live input.
    assign bus = bus_oe ? data_in[owner*WIDTH +: WIDTH] : {WIDTH{1'bz}};

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bus and per-channel data width in bits (range 1..64).
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of requesting channels (range 2..16).
REQ-003 Parameter TURNAROUND, default 1, SHALL set the number of forced bus-undriven cycles after each release (range 0..7).
REQ-004 Parameter MAX_HOLD, default 4, SHALL set the maximum tenure in cycles, where 0 means unlimited (range 0..255).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 req  input  CHANNELS  SHALL carry the per-channel bus request, level-sensitive, bit i = channel i.
REQ-008 data_in  input  CHANNELS*WIDTH  SHALL carry the packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 grant  output  CHANNELS  SHALL be the registered one-hot grant, or all-zero when no owner.
REQ-010 owner  output  clog2(CHANNELS)  SHALL be the registered index of the current owner, holding 0 when no owner.
REQ-011 bus_oe  output  1  SHALL be the registered bus drive enable.
REQ-012 bus  output  WIDTH  SHALL be tri-state: data_in of owner when bus_oe=1, else all bits 'z'.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DRIVE and TURN.
REQ-014 In IDLE with req!=0, the next edge SHALL enter DRIVE, set grant/owner to the round-robin pick and set bus_oe=1.
REQ-015 In IDLE with req=0, the FSM SHALL stay in IDLE with grant=0 and bus_oe=0.
REQ-016 The round-robin pick SHALL be the first set req bit scanning upward from pointer ptr, wrapping CHANNELS-1 -> 0.
REQ-017 bus SHALL follow data_in of owner combinationally within the same cycle while bus_oe=1, with no register stage on data.
REQ-018 In DRIVE, a hold counter SHALL count from 0 on entry and increment by 1 each cycle.
REQ-019 In DRIVE, release SHALL occur at the edge where req[owner]=0, or where MAX_HOLD!=0 and hold count = MAX_HOLD-1.
REQ-020 Simultaneous req drop and MAX_HOLD expiry SHALL produce a single release with identical behaviour.
REQ-021 On release, grant SHALL go to 0, bus_oe to 0 and ptr to (owner+1) mod CHANNELS, entering TURN, or IDLE if TURNAROUND=0.
REQ-022 TURN SHALL last exactly TURNAROUND cycles with bus='z', then go to IDLE; requests SHALL be ignored during TURN.
REQ-023 A request dropped in the first DRIVE cycle SHALL give a minimum tenure of 1 cycle.
REQ-024 The minimum gap between tenures SHALL be TURNAROUND+1 undriven cycles.
REQ-025 A preempted owner still requesting SHALL be re-eligible only after the round-robin scan passes all other requesters.
REQ-026 grant SHALL never have more than one bit set, and bus_oe=1 SHALL hold exactly when grant!=0.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, grant=0, owner=0, bus_oe=0, bus='z', ptr=0 and hold/turn counters to 0.
REQ-028 Reset asserted mid-DRIVE or mid-TURN SHALL abort the tenure; the first grant after reset release SHALL follow REQ-014 with ptr=0.

Structure
REQ-029 A shared package tristate_bus_pkg SHALL hold the state encodings IDLE=2'd0, DRIVE=2'd1, TURN=2'd2.
REQ-030 The round-robin selection SHALL be a sub-module rr_pick (inputs req and ptr; outputs one-hot pick, index and valid), combinational and parametrised by CHANNELS.
REQ-031 The top level SHALL contain the FSM, counters, ptr register and the tri-state driver.

Verification (WIDTH=8, CHANNELS=4, TURNAROUND=1, MAX_HOLD=4)
REQ-032 Reset: rst_n=0 mid-tenure with req=4'b1111 -> same time step bus=8'hzz, grant=0, bus_oe=0; after release, first grant=4'b0001.
REQ-033 Single requester: req=4'b0001, data_in[7:0]=8'hA5 -> 1 edge later grant=0001, bus=8'hA5; req->0 -> next edge bus=8'hzz; 1 TURN cycle, then IDLE.
REQ-034 Full contention: req=4'b1111 held, data_in bytes 8'h11/22/33/44 -> owners 0,1,2,3,0 in order, each 4 cycles, each gap 2 cycles of 8'hzz.
REQ-035 Live data: owner 2 holds, data_in[23:16] changes 8'h33 -> 8'h3C -> bus shows 8'h3C in the same cycle.
REQ-036 Wrap and skip: owner 3 releases with req=4'b0100 -> next grant=4'b0100 (ptr wraps to 0, channels 0 and 1 skipped).
REQ-037 Checkers on every cycle: onehot0(grant); bus_oe == (grant!=0); bus=='z' whenever bus_oe=0.
